// File: rtl/morse_symbol_classifier_if.sv
// Keying-line input and symbol-strobe output bundle for the Morse symbol classifier.
// The master drives the sampled key line; the slave (classifier) returns symbols.
interface morse_symbol_classifier_if;
  logic       sample_en;
  logic       serial_in;
  logic [1:0] sym;
  logic       sym_valid;
  logic       err;
  logic       in_word;

  modport master (
    output sample_en,
    output serial_in,
    input  sym,
    input  sym_valid,
    input  err,
    input  in_word
  );

  modport slave (
    input  sample_en,
    input  serial_in,
    output sym,
    output sym_valid,
    output err,
    output in_word
  );
endinterface

// File: rtl/morse_symbol_classifier.sv
// Measures mark/space run lengths on sample ticks and classifies them into dot, dash,
// letter-gap and word-gap strobes, flagging marks of invalid length.
module morse_symbol_classifier #(
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned DOT_MAX    = 2,
  parameter int unsigned DASH_MIN   = 3,
  parameter int unsigned MARK_MAX   = 6,
  parameter int unsigned LETTER_GAP = 3,
  parameter int unsigned WORD_GAP   = 7
) (
  input logic                          clk,
  input logic                          rst,
  morse_symbol_classifier_if.slave     bus_io
);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CntMax    = {CNT_W{1'b1}};
  localparam cnt_t DotMax    = cnt_t'(DOT_MAX);
  localparam cnt_t DashMin   = cnt_t'(DASH_MIN);
  localparam cnt_t MarkMax   = cnt_t'(MARK_MAX);
  localparam cnt_t LetterGap = cnt_t'(LETTER_GAP);
  localparam cnt_t WordGap   = cnt_t'(WORD_GAP);

  localparam logic [1:0] SymDot    = 2'b00;
  localparam logic [1:0] SymDash   = 2'b01;
  localparam logic [1:0] SymLetter = 2'b10;
  localparam logic [1:0] SymWord   = 2'b11;

  typedef enum logic [1:0] {StIdle, StMark, StSpace} state_e;

  state_e     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  cnt_t       cnt_inc;
  logic [1:0] sym_q, sym_d;
  logic       sym_valid_q, sym_valid_d;
  logic       err_q, err_d;
  logic       sample;
  logic       mark;

  assign sample  = bus_io.sample_en;
  assign mark    = bus_io.serial_in;
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + cnt_t'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sym_q       <= SymDot;
      sym_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (sample) begin
      unique case (state_q)
        StIdle: begin
          if (mark) begin
            state_d = StMark;
            cnt_d   = cnt_t'(1);
          end
        end
        StMark: begin
          if (mark) begin
            cnt_d = cnt_inc;
          end else begin
            state_d = StSpace;
            cnt_d   = cnt_t'(1);
          end
        end
        StSpace: begin
          if (mark) begin
            state_d = StMark;
            cnt_d   = cnt_t'(1);
          end else if (cnt_inc == WordGap) begin
            // Word gap closes the word; next gap symbols need a fresh mark first.
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Strobes are computed from the pre-sample state so they land one clk after the sample.
  always_comb begin
    sym_d       = sym_q;
    sym_valid_d = 1'b0;
    err_d       = 1'b0;
    if (sample) begin
      unique case (state_q)
        StMark: begin
          if (!mark) begin
            if (cnt_q <= DotMax) begin
              sym_d       = SymDot;
              sym_valid_d = 1'b1;
            end else if (cnt_q >= DashMin && cnt_q <= MarkMax) begin
              sym_d       = SymDash;
              sym_valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        StSpace: begin
          if (!mark) begin
            if (cnt_inc == LetterGap) begin
              sym_d       = SymLetter;
              sym_valid_d = 1'b1;
            end else if (cnt_inc == WordGap) begin
              sym_d       = SymWord;
              sym_valid_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_io.sym       = sym_q;
  assign bus_io.sym_valid = sym_valid_q;
  assign bus_io.err       = err_q;
  assign bus_io.in_word   = (state_q != StIdle);

endmodule

// File: tb/tb_morse_symbol_classifier.sv
// Scoreboard bench: stimulus pushes expected strobes (edge cycle + code), a monitor pops
// and compares them whenever the classifier raises sym_valid or err.
module tb_morse_symbol_classifier;

  typedef struct {
    int         cyc;
    logic [2:0] code;  // {err, sym}
  } exp_t;

  localparam logic [2:0] CDot    = 3'b000;
  localparam logic [2:0] CDash   = 3'b001;
  localparam logic [2:0] CLetter = 3'b010;
  localparam logic [2:0] CWord   = 3'b011;
  localparam logic [2:0] CErr    = 3'b100;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  morse_symbol_classifier_if bus ();

  morse_symbol_classifier dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && (bus.sym_valid || bus.err)) begin
      logic [2:0] act;
      exp_t       e;
      act = bus.err ? CErr : {1'b0, bus.sym};
      checks++;
      if (bus.sym_valid && bus.err) begin
        errors++;
        $display("FAIL strobe_overlap: sym_valid=1 err=1 at cyc %0d, required not both", cyc);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got code %03b at cyc %0d, required no strobe", act, cyc);
      end else begin
        e = exp_q.pop_front();
        if (act !== e.code || cyc != e.cyc) begin
          errors++;
          $display("FAIL strobe: got code %03b at cyc %0d, required code %03b at cyc %0d",
                   act, cyc, e.code, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // One sample: a single sample_en clk followed by three idle clks.
  task automatic samp(input logic v, input bit push, input logic [2:0] code);
    bus.serial_in = v;
    bus.sample_en = 1'b1;
    @(posedge clk);
    #1;
    if (push) exp_q.push_back('{cyc: cyc, code: code});
    bus.sample_en = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  // n high samples then the falling sample, which classifies the mark.
  task automatic mark_run(input int n, input logic [2:0] code);
    for (int i = 0; i < n; i++) samp(1'b1, 1'b0, CDot);
    samp(1'b0, 1'b1, code);
  endtask

  // Continue a space whose first low sample was the falling one, up to n lows total.
  task automatic gap(input int n);
    for (int k = 2; k <= n; k++) begin
      if (k == 3)      samp(1'b0, 1'b1, CLetter);
      else if (k == 7) samp(1'b0, 1'b1, CWord);
      else             samp(1'b0, 1'b0, CDot);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.sample_en = 1'b0;
    bus.serial_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_sym", {2'b0, bus.sym}, 4'h0);
    chk("reset_strobes", {2'b0, bus.sym_valid, bus.err}, 4'h0);
    chk("reset_in_word", {3'b0, bus.in_word}, 4'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: idle line produces nothing
    for (int i = 0; i < 20; i++) samp(1'b0, 1'b0, CDot);
    chk("idle_in_word", {3'b0, bus.in_word}, 4'h0);

    // 2: single-sample dot, then a full word gap
    mark_run(1, CDot);
    chk("dot_in_word", {3'b0, bus.in_word}, 4'h1);
    gap(7);
    chk("after_word_in_word", {3'b0, bus.in_word}, 4'h0);

    // 3: dash then gaps, trailing lows emit nothing and sym holds
    mark_run(3, CDash);
    gap(7);
    for (int i = 0; i < 20; i++) samp(1'b0, 1'b0, CDot);
    chk("hold_sym", {2'b0, bus.sym}, 4'h3);
    chk("hold_in_word", {3'b0, bus.in_word}, 4'h0);

    // 4: over-long and saturated marks
    mark_run(7, CErr);
    gap(7);
    mark_run(20, CErr);
    gap(7);

    // Boundaries: DOT_MAX and MARK_MAX
    mark_run(2, CDot);
    gap(3);
    mark_run(6, CDash);
    gap(7);

    // 5: key activity without sample_en must not advance anything
    samp(1'b1, 1'b0, CDot);
    for (int i = 0; i < 12; i++) begin
      bus.serial_in = ~bus.serial_in;
      @(posedge clk);
      #1;
    end
    chk("nosample_in_word", {3'b0, bus.in_word}, 4'h1);
    samp(1'b0, 1'b1, CDot);
    gap(7);
    samp(1'b1, 1'b0, CDot);
    samp(1'b1, 1'b0, CDot);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_word", {3'b0, bus.in_word}, 4'h0);
    chk("midrst_sym", {2'b0, bus.sym}, 4'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) samp(1'b0, 1'b0, CDot);
    chk("midrst_idle", {3'b0, bus.in_word}, 4'h0);

    // 6: ".-" then a letter gap, exactly three symbols
    mark_run(1, CDot);
    mark_run(3, CDash);
    gap(3);
    chk("a_in_word", {3'b0, bus.in_word}, 4'h1);

    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_strobes: got %0d outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
